// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin, packet-locked write arbiter for one fifo_small port.
// Revision : 1.0
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int size      = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*size-1:0]      din,
  input  logic [NREQ-1:0]           last,
  output logic [NREQ-1:0]           ack,
  input  logic                      fifo_full,
  output logic                      fifo_enw,
  output logic [size-1:0]           fifo_datain,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int c_IDW = $clog2(NREQ);
  localparam int c_CW  = $clog2(MAX_BURST + 1);

  generate
    if (NREQ < 2) begin : g_bad_nreq
      $error("fifo_wr_arbiter: NREQ must be at least 2");
    end
    if (MAX_BURST < 1) begin : g_bad_burst
      $error("fifo_wr_arbiter: MAX_BURST must be at least 1");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t            r_state;
  logic [c_IDW-1:0]  r_rr_ptr;
  logic [c_IDW-1:0]  r_grant_id;
  logic [c_CW-1:0]   r_beat_cnt;

  logic              w_any;
  logic [c_IDW-1:0]  w_pick;
  logic [c_IDW-1:0]  w_idx;
  logic              w_req_g;
  logic              w_last_g;
  logic [size-1:0]   w_din_g;
  logic              w_enw;
  logic [c_CW-1:0]   w_cnt_nxt;
  logic              w_burst_end;

  // First requester strictly after the last-served one, wrapping modulo NREQ.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = c_IDW'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_any && req[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  assign w_req_g     = req[r_grant_id];
  assign w_last_g    = last[r_grant_id];
  assign w_din_g     = din[int'(r_grant_id)*size +: size];
  assign w_enw       = (r_state == ST_GRANT) && w_req_g && !fifo_full;
  assign w_cnt_nxt   = r_beat_cnt + 1'b1;
  assign w_burst_end = (w_cnt_nxt == c_CW'(MAX_BURST));

  assign fifo_enw    = w_enw;
  assign fifo_datain = w_enw ? w_din_g : '0;
  assign ack         = w_enw ? (NREQ'(1) << r_grant_id) : '0;
  assign grant_id    = r_grant_id;
  assign busy        = (r_state == ST_GRANT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= c_IDW'(NREQ - 1);
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state    <= ST_GRANT;
            r_grant_id <= w_pick;
            r_beat_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (!w_req_g) begin
            // Producer withdrew mid-packet: give the port up without a write.
            r_state    <= ST_IDLE;
            r_rr_ptr   <= r_grant_id;
            r_grant_id <= '0;
          end else if (!fifo_full) begin
            r_beat_cnt <= w_cnt_nxt;
            if (w_last_g || w_burst_end) begin
              r_state    <= ST_IDLE;
              r_rr_ptr   <= r_grant_id;
              r_grant_id <= '0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  a_ack_onehot: assert property (@(posedge clk) disable iff (!rst)
    fifo_enw |-> $onehot(ack));
  a_enw_busy: assert property (@(posedge clk) disable iff (!rst)
    fifo_enw |-> busy);
  a_no_write_full: assert property (@(posedge clk) disable iff (!rst)
    fifo_full |-> !fifo_enw);

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Scoreboard bench for fifo_wr_arbiter (default and MAX_BURST=4).
// Revision : 1.0
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] din;
  logic [NREQ-1:0]   last;
  logic              fifo_full;

  logic [NREQ-1:0]   ack,  ack4;
  logic              enw,  enw4;
  logic [W-1:0]      data, data4;
  logic [1:0]        gid,  gid4;
  logic              busy, busy4;

  fifo_wr_arbiter #(.NREQ(NREQ), .size(W), .MAX_BURST(16)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .last(last), .ack(ack),
    .fifo_full(fifo_full), .fifo_enw(enw), .fifo_datain(data),
    .grant_id(gid), .busy(busy)
  );

  fifo_wr_arbiter #(.NREQ(NREQ), .size(W), .MAX_BURST(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .din(din), .last(last), .ack(ack4),
    .fifo_full(fifo_full), .fifo_enw(enw4), .fifo_datain(data4),
    .grant_id(gid4), .busy(busy4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Producer model: per-requester beat lists of {last, data}.
  logic [8:0]      beats [NREQ][32];
  int              head  [NREQ];
  int              len   [NREQ];
  logic [NREQ-1:0] drop;
  logic [9:0]      expq [$];
  logic            use4;

  logic            s_busy, s_enw;
  logic [NREQ-1:0] s_ack;
  logic [W-1:0]    s_data;
  logic [1:0]      s_gid;

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (head[i] < len[i] && !drop[i]) begin
        req[i]          = 1'b1;
        din[i*W +: W]   = beats[i][head[i]][7:0];
        last[i]         = beats[i][head[i]][8];
      end else begin
        req[i]          = 1'b0;
        din[i*W +: W]   = '0;
        last[i]         = 1'b0;
      end
    end
  endtask

  task automatic clear_prod();
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      len[i]  = 0;
    end
    drop = '0;
  endtask

  task automatic load(input int i, input logic [7:0] d, input logic l);
    beats[i][len[i]] = {l, d};
    len[i]++;
  endtask

  task automatic push(input logic [1:0] src, input logic [7:0] d);
    expq.push_back({src, d});
  endtask

  function automatic bit pending();
    for (int i = 0; i < NREQ; i++)
      if (head[i] < len[i]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: sample on the falling edge, score any write, advance producers.
  task automatic step();
    logic [9:0] e;
    @(negedge clk);
    s_busy = use4 ? busy4 : busy;
    s_enw  = use4 ? enw4  : enw;
    s_ack  = use4 ? ack4  : ack;
    s_data = use4 ? data4 : data;
    s_gid  = use4 ? gid4  : gid;
    checks++;
    if (s_enw) begin
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got src=%0d data=%02h, want no write", s_gid, s_data);
      end else begin
        e = expq.pop_front();
        if ({s_gid, s_data} !== e || s_ack !== (4'b0001 << s_gid)) begin
          errors++;
          $display("FAIL sb_beat got src=%0d data=%02h ack=%b, want src=%0d data=%02h ack=%b",
                   s_gid, s_data, s_ack, e[9:8], e[7:0], 4'b0001 << e[9:8]);
        end
      end
    end else if (s_ack !== '0 || s_data !== '0) begin
      errors++;
      $display("FAIL idle_outputs got ack=%b data=%02h, want ack=0000 data=00", s_ack, s_data);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (s_ack[i]) head[i]++;
    drive();
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((expq.size() != 0 || pending()) && n < bound) begin
      step();
      n++;
    end
    checks++;
    if (expq.size() != 0 || pending()) begin
      errors++;
      $display("FAIL drain_timeout got %0d beats outstanding, want 0", expq.size());
    end
    step();
    checks++;
    if (s_busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle got busy=%b, want 0", s_busy);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fifo_full = 1'b0;
    clear_prod();
    drive();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fifo_full = 1'b0;
    use4 = 1'b0;
    clear_prod();
    load(2, 8'hA5, 1'b1);
    drive();
    step();
    step();
    checks++;
    if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", s_busy); end
    checks++;
    if (s_enw !== 1'b0) begin errors++; $display("FAIL reset_enw got %b want 0", s_enw); end
    checks++;
    if (s_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b want 0000", s_ack); end
    checks++;
    if (s_data !== 8'h00) begin errors++; $display("FAIL reset_data got %02h want 00", s_data); end
    checks++;
    if (s_gid !== 2'd0) begin errors++; $display("FAIL reset_gid got %0d want 0", s_gid); end
    clear_prod();
    drive();
    rst = 1'b1;
  endtask

  task automatic test_single_packet();
    load(0, 8'h11, 1'b0); load(0, 8'h22, 1'b0); load(0, 8'h33, 1'b1);
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
    drive();
    step();
    checks++;
    if ({s_busy, s_enw} !== 2'b00) begin
      errors++; $display("FAIL single_latency got busy,enw=%b want 00", {s_busy, s_enw});
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({s_busy, s_enw, s_gid} !== 4'b1100) begin
        errors++; $display("FAIL single_burst beat%0d got busy,enw,gid=%b want 1100", k, {s_busy, s_enw, s_gid});
      end
    end
    step();
    checks++;
    if ({s_busy, s_enw} !== 2'b00) begin
      errors++; $display("FAIL single_release got busy,enw=%b want 00", {s_busy, s_enw});
    end
    checks++;
    if (expq.size() != 0) begin
      errors++; $display("FAIL single_outstanding got %0d want 0", expq.size());
    end
  endtask

  task automatic test_round_robin();
    int   grants;
    int   n;
    logic prev;
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NREQ; i++) begin
        load(i, 8'(8'h40 + k*16 + i), 1'b1);
        push(2'(i), 8'(8'h40 + k*16 + i));
      end
    drive();
    grants = 0;
    n = 0;
    prev = 1'b0;
    while ((expq.size() != 0 || pending()) && n < 40) begin
      step();
      n++;
      if (s_busy) begin
        grants++;
        checks++;
        if (prev) begin
          errors++; $display("FAIL rr_idle_gap got busy on consecutive cycles, want idle between grants");
        end
      end
      prev = s_busy;
    end
    checks++;
    if (grants != 8 || expq.size() != 0) begin
      errors++; $display("FAIL rr_grants got %0d grants %0d left, want 8 grants 0 left", grants, expq.size());
    end
    step();
  endtask

  task automatic test_backpressure();
    int nw;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      load(2, 8'(8'hC1 + k), k == 4);
      push(2, 8'(8'hC1 + k));
    end
    drive();
    nw = 0;
    step();
    for (int k = 0; k < 2; k++) begin
      step();
      if (s_enw) nw++;
    end
    fifo_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({s_enw, s_ack, s_busy, s_gid} !== {1'b0, 4'b0000, 1'b1, 2'd2}) begin
        errors++; $display("FAIL bp_hold got enw,ack,busy,gid=%b want 0000012", {s_enw, s_ack, s_busy, s_gid});
      end
    end
    fifo_full = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (s_enw) nw++;
    end
    checks++;
    if (nw != 5) begin
      errors++; $display("FAIL bp_total got %0d writes want 5", nw);
    end
    drain(10);
  endtask

  task automatic test_max_burst();
    int   rises;
    int   n;
    logic prev;
    use4 = 1'b1;
    do_reset();
    for (int k = 0; k < 10; k++) load(1, 8'(8'h10 + k), k == 9);
    load(3, 8'h30, 1'b0);
    load(3, 8'h31, 1'b1);
    for (int k = 0; k < 4; k++) push(1, 8'(8'h10 + k));
    push(3, 8'h30); push(3, 8'h31);
    for (int k = 4; k < 10; k++) push(1, 8'(8'h10 + k));
    drive();
    rises = 0;
    n = 0;
    prev = 1'b0;
    while ((expq.size() != 0 || pending()) && n < 60) begin
      step();
      n++;
      if (s_busy && !prev) rises++;
      prev = s_busy;
    end
    checks++;
    if (rises != 4 || expq.size() != 0) begin
      errors++; $display("FAIL burst_split got %0d grants %0d left, want 4 grants 0 left", rises, expq.size());
    end
    step();
    use4 = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) load(1, 8'(8'h71 + k), k == 3);
    push(1, 8'h71); push(1, 8'h72);
    drive();
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if (s_enw !== 1'b1) begin
      errors++; $display("FAIL rstmid_beat2 got enw=%b want 1", s_enw);
    end
    clear_prod();
    rst = 1'b1;
    load(0, 8'h0A, 1'b1);
    load(2, 8'h2A, 1'b1);
    push(0, 8'h0A); push(2, 8'h2A);
    drive();
    step();
    checks++;
    if ({s_busy, s_enw} !== 2'b00) begin
      errors++; $display("FAIL rstmid_abort got busy,enw=%b want 00", {s_busy, s_enw});
    end
    step();
    checks++;
    if ({s_busy, s_gid} !== 3'b100) begin
      errors++; $display("FAIL rstmid_priority got busy,gid=%b want 100", {s_busy, s_gid});
    end
    drain(20);
  endtask

  task automatic test_drop();
    do_reset();
    for (int k = 0; k < 4; k++) load(1, 8'(8'h81 + k), k == 3);
    load(2, 8'h91, 1'b1);
    push(1, 8'h81); push(1, 8'h82); push(2, 8'h91); push(1, 8'h83); push(1, 8'h84);
    drive();
    step();
    step();
    step();
    drop[1] = 1'b1;
    drive();
    step();
    checks++;
    if ({s_busy, s_enw, s_ack} !== 6'b100000) begin
      errors++; $display("FAIL drop_release got busy,enw,ack=%b want 100000", {s_busy, s_enw, s_ack});
    end
    drop[1] = 1'b0;
    drive();
    step();
    checks++;
    if (s_busy !== 1'b0) begin
      errors++; $display("FAIL drop_idle got busy=%b want 0", s_busy);
    end
    step();
    checks++;
    if ({s_busy, s_gid} !== 3'b110) begin
      errors++; $display("FAIL drop_next_grant got busy,gid=%b want 110", {s_busy, s_gid});
    end
    drain(20);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    fifo_full = 1'b0;
    use4 = 1'b0;
    req = '0;
    din = '0;
    last = '0;
    clear_prod();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_max_burst();
    test_reset_mid();
    test_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `fifo_small` write port among `NREQ` producer streams in the median-filter datapath. Each producer presents packets of `size`-bit beats. The arbiter locks the FIFO to one producer for a whole packet, or until `MAX_BURST` beats have been written. It honours FIFO backpressure through `full` and reports which source owns the port, so downstream logic can attribute data.

## Interface
Parameters:
- `NREQ`, 4, number of requesters; must be ≥2.
- `size`, 8, beat width in bits; must match the FIFO `size`.
- `MAX_BURST`, 16, maximum beats per grant; must be ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset, sampled on `posedge clk`.
- `req` in `NREQ`: per-requester request; held high while beats are pending.
- `din` in `NREQ*size`: requester i's beat is in bits `[i*size +: size]`.
- `last` in `NREQ`: marks the final beat of the packet for requester i.
- `ack` out `NREQ`: beat of requester i is accepted this cycle.
- `fifo_full` in 1: connects to the FIFO `full` output.
- `fifo_enw` out 1: connects to the FIFO `enw` input.
- `fifo_datain` out `size`: connects to the FIFO `datain` input.
- `grant_id` out `$clog2(NREQ)`: index of the current owner; valid while `busy`=1.
- `busy` out 1: a grant is active.

## Operation
- State machine has two states, IDLE and GRANT. Registers:
  - `rr_ptr` (last-served index)
  - `grant_id`
  - `beat_cnt` (width `$clog2(MAX_BURST+1)`)
- IDLE:
  - If any `req` bit is high, pick the first set bit at or after `rr_ptr+1`, searching modulo `NREQ` (wrap NREQ-1 → 0).
  - Load `grant_id` with it, clear `beat_cnt`, go to GRANT.
  - Else stay in IDLE.
  - No beat is ever accepted in IDLE.
- GRANT, with g = `grant_id`:
  - A beat is accepted when `req[g]`=1 and `fifo_full`=0.
  - On an accepted beat, `beat_cnt` increments.
  - On an accepted beat with `last[g]`=1, or with `beat_cnt`+1 == `MAX_BURST`: release (go to IDLE, `rr_ptr`←g).
  - `req[g]`=0: release immediately, no beat written, `rr_ptr`←g.
  - `fifo_full`=1 with `req[g]`=1: hold the grant, no write, `beat_cnt` unchanged.
- Combinational outputs:
  - `fifo_enw` = GRANT & `req[g]` & !`fifo_full`.
  - `ack` = one-hot of g when `fifo_enw` is high, else 0.
  - `fifo_datain` = granted slice of `din` when `fifo_enw` is high, else all zeros.
- `busy` = (state == GRANT). `grant_id` is 0 in IDLE.
- A requester whose `req` rises while another requester holds the grant waits; it never pre-empts.
- A packet longer than `MAX_BURST` is split. The requester re-arbitrates after the split and sees the other requesters served first if they are pending.
- `last` is ignored unless its requester is granted and the beat is accepted.

## Timing
- Reset (`rst`=0 at a clock edge): state←IDLE, `rr_ptr`←NREQ-1 (so requester 0 has first priority), `grant_id`←0, `beat_cnt`←0.
  - Combinationally, while in reset state: `busy`=0, `fifo_enw`=0, `ack`=0, `fifo_datain`=0.
- Reset mid-burst aborts the grant at that edge. Beats already written stay in the FIFO; no further writes occur.
- Latency: `req` first high in IDLE at cycle t → `busy`=1 and first possible write at t+1.
- Throughput: one beat per cycle while granted and not full.
- At least one IDLE cycle separates consecutive grants, including the same requester regaining the grant.
- `fifo_full` changing mid-cycle is not allowed: it must come from FIFO registers, as the `fifo_small` `full` output does.
- With `fifo_full`=1 for the entire grant, the grant is held indefinitely. No timeout.

## Test plan
- Reset, then req[0]=1 with beats 0x11, 0x22, 0x33 (last on 0x33), `fifo_full`=0 → `busy` rises 1 cycle after req; `fifo_enw` high 3 consecutive cycles; FIFO holds 11, 22, 33; IDLE on the next cycle.
- req=4'b1111 continuously, each packet 1 beat → grant order 0,1,2,3,0…, with one IDLE cycle between grants; `ack` one-hot matches `grant_id`.
- req[2]=1 with a 5-beat packet; `fifo_full` forced high during beat 3 for 4 cycles → `fifo_enw`=0 and `ack`=0 for those 4 cycles; data order intact; `beat_cnt` resumes; 5 beats written total.
- `MAX_BURST`=4, req[1] sends a 10-beat packet while req[3]=1 → writes 4 beats of requester 1, then requester 3's packet, then 4 beats of requester 1, then 2 beats of requester 1.
- `rst`=0 asserted on beat 2 of a 4-beat grant → `busy`=0 and `fifo_enw`=0 on the following cycle; after release, requester 0 has priority over a pending requester 2.
- Granted req[1] drops without `last` → release on that cycle with no write; `rr_ptr`=1, so a pending req[2] is granted next.
